// File: rtl/bus_rr_sched.sv
// Round-robin bus scheduler: pops one package at a time from the granted driver
// and delivers it as a unicast, a broadcast (all but the source), or drops it.
module bus_rr_sched #(
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         pndng,
  input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]         pop,
  output logic [DRVRS-1:0]         push,
  output logic [PCKG_SZ-1:0]       D_push,
  output logic [3:0]               gnt_id,
  output logic                     drop,
  output logic [15:0]              pkt_cnt,
  output logic [1:0]               o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_gnt_id;
  logic [3:0]           r_last_gnt;
  logic [PCKG_SZ-1:0]   r_data;
  logic [15:0]          r_pkt_cnt;
  logic [3:0]           w_winner;
  logic [4:0]           w_idx;
  logic                 w_any;
  logic                 w_load;
  logic [PCKG_SZ-1:0]   w_cap;
  logic [7:0]           w_cap_dest;
  logic                 w_cap_ok;
  logic [7:0]           w_dest;
  logic [DRVRS-1:0]     w_gnt_oh;

  // Walk from the farthest candidate to the nearest so the nearest pending
  // driver after r_last_gnt overwrites the others and wins.
  always_comb begin
    w_any    = |pndng;
    w_winner = r_last_gnt;
    w_idx    = '0;
    for (int k = DRVRS; k >= 1; k--) begin
      w_idx = 5'(r_last_gnt) + 5'(k);
      if (w_idx >= 5'(DRVRS)) w_idx = w_idx - 5'(DRVRS);
      for (int j = 0; j < DRVRS; j++) begin
        if ((w_idx == 5'(j)) && pndng[j]) w_winner = 4'(j);
      end
    end
  end

  always_comb begin
    w_cap = '0;
    for (int j = 0; j < DRVRS; j++) begin
      if (r_gnt_id == 4'(j)) w_cap = D_pop[j*PCKG_SZ +: PCKG_SZ];
    end
    w_cap_dest = w_cap[PCKG_SZ-1 -: 8];
    w_cap_ok   = (w_cap_dest < 8'(DRVRS)) || (w_cap_dest == BROADCAST);
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_next = POP;
        w_load = 1'b1;
      end
      POP:  w_next = PUSH;
      PUSH: begin
        w_next = w_any ? POP : IDLE;
        w_load = w_any;
      end
      default: w_next = IDLE;
    endcase
  end

  // The delivery count is committed at capture, so it is already visible
  // during the PUSH cycle of the package it counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_gnt_id   <= '0;
      r_last_gnt <= 4'(DRVRS - 1);
      r_data     <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_gnt_id   <= w_winner;
        r_last_gnt <= w_winner;
      end
      if (r_state == POP) begin
        r_data <= w_cap;
        if (w_cap_ok) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
    end
  end

  // Strobes decode only registered state, never the inputs.
  always_comb begin
    w_dest = r_data[PCKG_SZ-1 -: 8];
    pop    = '0;
    push   = '0;
    drop   = 1'b0;
    for (int j = 0; j < DRVRS; j++) w_gnt_oh[j] = (r_gnt_id == 4'(j));
    if (r_state == POP) pop = w_gnt_oh;
    if (r_state == PUSH) begin
      if (w_dest < 8'(DRVRS)) begin
        for (int j = 0; j < DRVRS; j++) push[j] = (w_dest == 8'(j));
      end else if (w_dest == BROADCAST) begin
        push = ~w_gnt_oh;
      end else begin
        drop = 1'b1;
      end
    end
  end

  assign D_push  = r_data;
  assign gnt_id  = r_gnt_id;
  assign pkt_cnt = r_pkt_cnt;
  assign o_state = r_state;

endmodule

// File: doc/bus_rr_sched.md
BUS_RR_SCHED -- requirements
Module: bus_rr_sched

Interface
REQ-001 Parameter DRVRS, default 4, SHALL be the number of bus drivers/requesters (2..16).
REQ-002 Parameter PCKG_SZ, default 16, SHALL be the package width in bits (>= 9).
REQ-003 Parameter BROADCAST, default 8'hFF, SHALL be the destination ID meaning "all drivers except source".
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset (0 = reset asserted).
REQ-006 pndng  input  DRVRS  SHALL be the per-driver "package pending" flags.
REQ-007 D_pop  input  DRVRS*PCKG_SZ  SHALL carry each driver's head package, driver i at bits [i*PCKG_SZ +: PCKG_SZ].
REQ-008 pop  output  DRVRS  SHALL be the one-hot pop strobe to the granted driver.
REQ-009 push  output  DRVRS  SHALL be the per-driver delivery strobes.
REQ-010 D_push  output  PCKG_SZ  SHALL be the shared bus data, valid whenever any push bit is 1.
REQ-011 gnt_id  output  4  SHALL be the index of the currently or last granted driver.
REQ-012 drop  output  1  SHALL pulse for one cycle when a package is discarded.
REQ-013 pkt_cnt  output  16  SHALL count delivered (non-dropped) packages.

Function
REQ-014 Destination field SHALL be the captured package bits [PCKG_SZ-1 -: 8].
REQ-015 FSM states SHALL be IDLE, POP, PUSH.
REQ-016 IDLE: if any pndng bit is 1 at a rising edge, SHALL load gnt_id with the round-robin winner and go to POP; otherwise stay.
REQ-017 Round-robin winner SHALL be the first i with pndng[i]=1, searching from (last_gnt+1) mod DRVRS upward with wrap.
REQ-018 POP: pop[gnt_id] SHALL be 1 for exactly this one cycle; D_pop[gnt_id] SHALL be captured at the end of this cycle; next state PUSH.
REQ-019 PUSH, dest < DRVRS: push[dest]=1 only (self-addressed dest == gnt_id permitted); pkt_cnt increments by 1.
REQ-020 PUSH, dest == BROADCAST: push SHALL be 1 on every bit except gnt_id; pkt_cnt increments by 1.
REQ-021 PUSH, dest >= DRVRS and != BROADCAST: push SHALL stay all-zero, drop SHALL be 1 this cycle, pkt_cnt unchanged.
REQ-022 D_push SHALL hold the captured package throughout PUSH and keep it until the next capture.
REQ-023 PUSH exit: if any pndng is 1, SHALL go directly to POP with a new round-robin grant (2 cycles/package sustained); else IDLE.
REQ-024 last_gnt SHALL update to gnt_id on each POP entry; the just-served driver is therefore lowest priority next.
REQ-025 pndng SHALL be ignored outside IDLE and the PUSH-exit decision; pndng dropping during POP SHALL NOT abort the transfer.
REQ-026 pkt_cnt SHALL wrap 16'hFFFF -> 16'h0000.
REQ-027 pop, push, drop SHALL be decoded only from registered state (no combinational input-to-output path).
REQ-028 At most one pop bit SHALL ever be 1; pop and push SHALL never be nonzero in the same cycle.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, pop=0, push=0, drop=0, D_push=0, gnt_id=0, pkt_cnt=0, last_gnt=DRVRS-1 (first grant favours driver 0).
REQ-030 Reset asserted during POP or PUSH SHALL abandon the package: no further push for it, pkt_cnt not incremented.
REQ-031 After reset release, first grant SHALL occur no earlier than the first rising edge with reset=1.

Verification (DRVRS=4, PCKG_SZ=16)
REQ-032 Single unicast: pndng=4'b0010, D_pop[1]=16'h03AB -> pop=4'b0010 one cycle, next cycle push=4'b1000, D_push=16'h03AB, pkt_cnt=1.
REQ-033 Broadcast: pndng=4'b0100, D_pop[2]=16'hFF5A -> push=4'b1011, D_push=16'hFF5A, pkt_cnt=1.
REQ-034 Fairness: pndng=4'b1111 held constant from reset -> grant order 0,1,2,3,0,..., one pop every 2 cycles, no pop/push overlap.
REQ-035 Invalid destination: D_pop[0]=16'h07FF, pndng=4'b0001 -> pop=4'b0001, then push=4'b0000, drop=1 one cycle, pkt_cnt unchanged.
REQ-036 Reset mid-PUSH: assert reset in PUSH cycle -> push=0 immediately, pkt_cnt=0; after release with pndng=4'b1000 first grant is driver 3 within 2 edges.
REQ-037 Wrap: preload 65535 deliveries (or force) then one more unicast -> pkt_cnt=16'h0000.
